// File: rtl/raw_pkg.sv
// raw_pkg: shared definitions for the raw operand stage.
//   - default operand / PHV geometry
//   - configuration register addresses
//   - operand bundle and skid-entry types
// The struct types are sized from the defaults below; the top-level
// parameters default to the same values and must stay consistent with them.
package raw_pkg;

  localparam int DEFAULT_COUNT_WIDTH = 32;
  localparam int DEFAULT_NUM_FIELDS  = 8;

  localparam logic [1:0] CFG_CONSTANT = 2'd0;
  localparam logic [1:0] CFG_IDX      = 2'd1;
  localparam logic [1:0] CFG_SEL      = 2'd2;

  // Operand bundle presented to the read-add-write atom.
  typedef struct packed {
    logic [DEFAULT_COUNT_WIDTH-1:0] constant;
    logic [DEFAULT_COUNT_WIDTH-1:0] pkt_1;
    logic                           sel1;
    logic                           sel2;
  } raw_operand_t;

  // One buffered packet: the PHV plus the operands snapshotted at accept.
  typedef struct packed {
    logic [DEFAULT_NUM_FIELDS*DEFAULT_COUNT_WIDTH-1:0] phv;
    raw_operand_t                                      op;
  } raw_entry_t;

endpackage

// File: rtl/raw_skid_buffer.sv
// raw_skid_buffer: generic 2-entry valid/ready FIFO.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   up_data/up_valid/up_ready   upstream side; up_ready is a flop output
//   dn_data/dn_valid/dn_ready   downstream side; head entry drives dn_data
// up_ready depends only on registered occupancy, so there is no
// combinational path from dn_ready to up_ready.
module raw_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] up_data,
  input  logic             up_valid,
  output logic             up_ready,
  output logic [WIDTH-1:0] dn_data,
  output logic             dn_valid,
  input  logic             dn_ready
);

  logic [WIDTH-1:0] head_r;
  logic [WIDTH-1:0] tail_r;
  logic [1:0]       occ_r;
  logic [1:0]       occ_s;
  logic             ready_r;
  logic             push_s;
  logic             pop_s;

  assign push_s   = up_valid && ready_r;
  assign pop_s    = (occ_r != 2'd0) && dn_ready;
  assign up_ready = ready_r;
  assign dn_valid = (occ_r != 2'd0);
  assign dn_data  = head_r;

  // Next occupancy from push/pop; simultaneous push+pop leaves it unchanged.
  always_comb begin
    occ_s = occ_r;
    case ({push_s, pop_s})
      2'b10:   occ_s = occ_r + 2'd1;
      2'b01:   occ_s = occ_r - 2'd1;
      default: occ_s = occ_r;
    endcase
  end

  // Storage, occupancy and registered ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r  <= '0;
      tail_r  <= '0;
      occ_r   <= 2'd0;
      ready_r <= 1'b1;
    end else begin
      occ_r   <= occ_s;
      ready_r <= (occ_s != 2'd2);
      case ({push_s, pop_s})
        2'b10: begin
          if (occ_r == 2'd0) begin
            head_r <= up_data;
          end else begin
            tail_r <= up_data;
          end
        end
        2'b01: begin
          head_r <= tail_r;
        end
        2'b11: begin
          // A push is only possible at occupancy 0 or 1; pop needs 1 or more.
          if (occ_r == 2'd1) begin
            head_r <= up_data;
          end else begin
            head_r <= tail_r;
            tail_r <= up_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/raw_operand_stage.sv
// raw_operand_stage: feeder for the read-add-write stateful atom.
// Accepts PHVs (valid/ready), snapshots {PHV field cfg_idx, constant, sel1,
// sel2} into a 2-entry skid buffer, and presents the head's operands to the
// atom only on the cycle the head is handed downstream. All other cycles
// drive zero operands so the atom's unconditional update writes 0 + reg.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   i__phv, i__phv_valid, o__phv_ready   upstream PHV handshake
//   o__valid, o__phv, i__ready    downstream PHV handshake (head entry)
//   o__constant, o__pkt_1, o__sel1, o__sel2   atom operands
//   i__cfg_we, i__cfg_addr, i__cfg_wdata      config write port
//   o__pkt_count                  packets issued to the atom (wraps)
module raw_operand_stage
  import raw_pkg::*;
#(
  parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH,
  parameter int NUM_FIELDS  = DEFAULT_NUM_FIELDS
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_FIELDS*COUNT_WIDTH-1:0] i__phv,
  input  logic                              i__phv_valid,
  output logic                              o__phv_ready,
  input  logic                              i__ready,
  output logic                              o__valid,
  output logic [NUM_FIELDS*COUNT_WIDTH-1:0] o__phv,
  output logic [COUNT_WIDTH-1:0]            o__constant,
  output logic [COUNT_WIDTH-1:0]            o__pkt_1,
  output logic                              o__sel1,
  output logic                              o__sel2,
  input  logic                              i__cfg_we,
  input  logic [1:0]                        i__cfg_addr,
  input  logic [COUNT_WIDTH-1:0]            i__cfg_wdata,
  output logic [31:0]                       o__pkt_count
);

  localparam int IDX_WIDTH = $clog2(NUM_FIELDS);

  logic [COUNT_WIDTH-1:0] cfg_constant_r;
  logic [IDX_WIDTH-1:0]   cfg_idx_r;
  logic                   cfg_sel1_r;
  logic                   cfg_sel2_r;
  logic [31:0]            pkt_count_r;

  logic [COUNT_WIDTH-1:0] fields_s [NUM_FIELDS];
  raw_entry_t             push_entry_s;
  raw_entry_t             head_entry_s;
  logic                   head_valid_s;
  logic                   fire_s;

  for (genvar k = 0; k < NUM_FIELDS; k++) begin : g_fields
    assign fields_s[k] = i__phv[k*COUNT_WIDTH +: COUNT_WIDTH];
  end

  // Entry snapshot uses the config as it stood before this cycle's write.
  always_comb begin
    push_entry_s             = '0;
    push_entry_s.phv         = i__phv;
    push_entry_s.op.constant = cfg_constant_r;
    push_entry_s.op.pkt_1    = fields_s[cfg_idx_r];
    push_entry_s.op.sel1     = cfg_sel1_r;
    push_entry_s.op.sel2     = cfg_sel2_r;
  end

  raw_skid_buffer #(
    .WIDTH ($bits(raw_entry_t))
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .up_data  (push_entry_s),
    .up_valid (i__phv_valid),
    .up_ready (o__phv_ready),
    .dn_data  (head_entry_s),
    .dn_valid (head_valid_s),
    .dn_ready (i__ready)
  );

  assign fire_s       = head_valid_s && i__ready;
  assign o__valid     = head_valid_s;
  assign o__phv       = head_entry_s.phv;
  assign o__pkt_count = pkt_count_r;

  // Operands are live only on the fire cycle; otherwise hold (all zero).
  always_comb begin
    o__constant = '0;
    o__pkt_1    = '0;
    o__sel1     = 1'b0;
    o__sel2     = 1'b0;
    if (fire_s) begin
      o__constant = head_entry_s.op.constant;
      o__pkt_1    = head_entry_s.op.pkt_1;
      o__sel1     = head_entry_s.op.sel1;
      o__sel2     = head_entry_s.op.sel2;
    end else begin
      o__constant = '0;
      o__pkt_1    = '0;
      o__sel1     = 1'b0;
      o__sel2     = 1'b0;
    end
  end

  // Config registers; an out-of-range field index write is dropped whole.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_constant_r <= '0;
      cfg_idx_r      <= '0;
      cfg_sel1_r     <= 1'b0;
      cfg_sel2_r     <= 1'b0;
    end else if (i__cfg_we) begin
      case (i__cfg_addr)
        CFG_CONSTANT: cfg_constant_r <= i__cfg_wdata;
        CFG_IDX: begin
          if (i__cfg_wdata < COUNT_WIDTH'(NUM_FIELDS)) begin
            cfg_idx_r <= i__cfg_wdata[IDX_WIDTH-1:0];
          end
        end
        CFG_SEL: begin
          cfg_sel1_r <= i__cfg_wdata[0];
          cfg_sel2_r <= i__cfg_wdata[1];
        end
        default: begin
        end
      endcase
    end
  end

  // Issued-packet counter; wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_count_r <= 32'd0;
    end else if (fire_s) begin
      pkt_count_r <= pkt_count_r + 32'd1;
    end
  end

endmodule
